outport_tx_fifo: RTL

- Output-side transmitter between the processor's port-write path and four external 8-bit channels.
- Processor writes (strobe, 2-bit port select, data) are buffered in per-channel FIFOs.
- Buffered bytes are delivered to the external world with a valid/acknowledge handshake per channel.
- Replaces unconditional overwrite of the OutExtWorld registers with flow-controlled, loss-detecting delivery.

---
 rtl/outport_tx_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/outport_tx_fifo.sv
// Port-write transmitter: buffers processor writes into four per-channel FIFOs
// and delivers them to the external world with a valid/acknowledge handshake.
module outport_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             OUTportWrite,
    input  logic [1:0]       PortSel,
    input  logic [WIDTH-1:0] Datain,
    output logic [3:0]       PortFull,
    output logic [3:0]       Overflow,
    input  logic [3:0]       OvfClear,
    output logic [WIDTH-1:0] OutExtWorld1,
    output logic [WIDTH-1:0] OutExtWorld2,
    output logic [WIDTH-1:0] OutExtWorld3,
    output logic [WIDTH-1:0] OutExtWorld4,
    output logic [3:0]       OutValid,
    input  logic [3:0]       OutAck
);

    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

    logic [WIDTH-1:0] headOut_s [4];

    for (genvar ch = 0; ch < 4; ch++) begin : gCh
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic [PTRW-1:0]  wrPtr_r;
        logic [PTRW-1:0]  rdPtr_r;
        logic [PTRW-1:0]  rdPtrNext_s;
        logic [PTRW:0]    count_r;
        logic [PTRW:0]    countNext_s;
        logic             valid_r;
        logic             full_r;
        logic             ovf_r;
        logic [WIDTH-1:0] head_r;
        logic [WIDTH-1:0] headNext_s;
        logic             sel_s;
        logic             pop_s;
        logic             push_s;
        logic             drop_s;

        // Next-state decode: push/pop/drop and the post-edge head byte
        always_comb begin
            sel_s       = OUTportWrite && (PortSel == 2'(ch));
            pop_s       = valid_r && OutAck[ch];
            push_s      = sel_s && (!full_r || pop_s);
            drop_s      = sel_s && full_r && !pop_s;
            rdPtrNext_s = pop_s ? (rdPtr_r + PTRW'(1)) : rdPtr_r;
            if (push_s && !pop_s) begin
                countNext_s = count_r + (PTRW + 1)'(1);
            end else if (pop_s && !push_s) begin
                countNext_s = count_r - (PTRW + 1)'(1);
            end else begin
                countNext_s = count_r;
            end
            // A byte written this edge into the slot that becomes the head bypasses the memory
            if (countNext_s == (PTRW + 1)'(0)) begin
                headNext_s = head_r;
            end else if (push_s && (wrPtr_r == rdPtrNext_s)) begin
                headNext_s = Datain;
            end else begin
                headNext_s = mem_r[rdPtrNext_s];
            end
        end

        // Channel state and registered outputs
        always_ff @(posedge clk) begin
            if (!Reset) begin
                wrPtr_r <= '0;
                rdPtr_r <= '0;
                count_r <= '0;
                valid_r <= 1'b0;
                full_r  <= 1'b0;
                ovf_r   <= 1'b0;
                head_r  <= '0;
            end else begin
                if (push_s) begin
                    mem_r[wrPtr_r] <= Datain;
                    wrPtr_r        <= wrPtr_r + PTRW'(1);
                end
                rdPtr_r <= rdPtrNext_s;
                count_r <= countNext_s;
                valid_r <= (countNext_s != (PTRW + 1)'(0));
                full_r  <= (countNext_s == FULL_COUNT);
                head_r  <= headNext_s;
                if (drop_s) begin
                    ovf_r <= 1'b1;
                end else if (OvfClear[ch]) begin
                    ovf_r <= 1'b0;
                end else begin
                    ovf_r <= ovf_r;
                end
            end
        end

        assign OutValid[ch]  = valid_r;
        assign PortFull[ch]  = full_r;
        assign Overflow[ch]  = ovf_r;
        assign headOut_s[ch] = head_r;
    end

    assign OutExtWorld1 = headOut_s[0];
    assign OutExtWorld2 = headOut_s[1];
    assign OutExtWorld3 = headOut_s[2];
    assign OutExtWorld4 = headOut_s[3];

endmodule
